// File: rtl/dck_loader_pkg.sv
// Shared types and constants for the DCK cartridge image loader.
package dck_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BANK,
    S_TYPE,
    S_DATA,
    S_SKIP,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0] ABSENT     = 8'd0;
  localparam logic [7:0] RAM_NODATA = 8'd1;
  localparam logic [7:0] ROM_DATA   = 8'd2;
  localparam logic [7:0] RAM_DATA   = 8'd3;

  localparam int CHUNK_BYTES = 8192;

endpackage

// File: rtl/dck_loader_chunk_sel.sv
// Finds the lowest data-bearing chunk at or above a start index.
module dck_loader_chunk_sel (
  input  logic [7:0] mask_i,
  input  logic [2:0] start_i,
  output logic [2:0] idx_o,
  output logic       none_o
);

  // Scanning downwards lets the lowest qualifying index win.
  always_comb begin
    idx_o  = 3'd0;
    none_o = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      if (mask_i[i] && (3'(i) >= start_i)) begin
        idx_o  = 3'(i);
        none_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/dck_loader.sv
// Parses a DCK download stream, writes the selected bank's chunks into the
// 64 KB DOCK region and builds the present/ROM chunk maps.
module dck_loader
  import dck_loader_pkg::*;
#(
  parameter logic [7:0] BANK_ID = 8'd0
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [7:0]  dl_data,
  output logic        wr_req,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [7:0]  dock_map,
  output logic [7:0]  dock_rom,
  output logic        done,
  output logic        error
);

  state_t      state_q, state_d;
  logic        active_q;
  logic [7:0]  bank_q, bank_d;
  logic [2:0]  tidx_q, tidx_d;
  logic [7:0]  dmask_q, dmask_d;
  logic [7:0]  pmap_q, pmap_d;
  logic [7:0]  prom_q, prom_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [12:0] cnt_q, cnt_d;
  logic        wr_req_q, wr_req_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [7:0]  map_q, map_d;
  logic [7:0]  rom_q, rom_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic       rise, fall, accept;
  logic [7:0] bit_sel, cur_dmask, cur_pmap, cur_prom;
  logic       t_data, t_present, t_rom, t_bad;
  logic [7:0] sel_mask;
  logic [2:0] sel_start, sel_idx;
  logic       sel_none, last_chunk;

  assign rise   = dl_active & ~active_q;
  assign fall   = ~dl_active & active_q;
  // A byte strobed in the very cycle dl_active drops still belongs to the file.
  assign accept = dl_wr & (dl_active | active_q);

  assign t_bad     = dl_data > RAM_DATA;
  assign t_data    = (dl_data == ROM_DATA) || (dl_data == RAM_DATA);
  assign t_present = (dl_data != ABSENT) && !t_bad;
  assign t_rom     = dl_data == ROM_DATA;

  assign bit_sel   = 8'b1 << tidx_q;
  assign cur_dmask = dmask_q | (t_data    ? bit_sel : 8'h00);
  assign cur_pmap  = pmap_q  | (t_present ? bit_sel : 8'h00);
  assign cur_prom  = prom_q  | (t_rom     ? bit_sel : 8'h00);

  assign sel_mask   = (state_q == S_TYPE) ? cur_dmask : dmask_q;
  assign sel_start  = (state_q == S_TYPE) ? 3'd0 : ptr_q + 3'd1;
  assign last_chunk = (ptr_q == 3'd7) | sel_none;

  dck_loader_chunk_sel u_chunk_sel (
    .mask_i  (sel_mask),
    .start_i (sel_start),
    .idx_o   (sel_idx),
    .none_o  (sel_none)
  );

  always_comb begin
    state_d   = state_q;
    bank_d    = bank_q;
    tidx_d    = tidx_q;
    dmask_d   = dmask_q;
    pmap_d    = pmap_q;
    prom_d    = prom_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    wr_req_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    map_d     = map_q;
    rom_d     = rom_q;
    done_d    = done_q;
    error_d   = error_q;

    if (rise) begin
      state_d = S_BANK;
      tidx_d  = 3'd0;
      dmask_d = 8'h00;
      pmap_d  = 8'h00;
      prom_d  = 8'h00;
      ptr_d   = 3'd0;
      cnt_d   = 13'd0;
      map_d   = 8'h00;
      rom_d   = 8'h00;
      done_d  = 1'b0;
      error_d = 1'b0;
    end else begin
      if (accept) begin
        case (state_q)
          S_BANK: begin
            bank_d  = dl_data;
            tidx_d  = 3'd0;
            dmask_d = 8'h00;
            pmap_d  = 8'h00;
            prom_d  = 8'h00;
            state_d = S_TYPE;
          end
          S_TYPE: begin
            if (t_bad) begin
              state_d = S_ERR;
              error_d = 1'b1;
            end else begin
              dmask_d = cur_dmask;
              pmap_d  = cur_pmap;
              prom_d  = cur_prom;
              tidx_d  = tidx_q + 3'd1;
              if (tidx_q == 3'd7) begin
                if (bank_q == BANK_ID) begin
                  map_d = map_q | cur_pmap;
                  rom_d = rom_q | cur_prom;
                end
                ptr_d = sel_idx;
                cnt_d = 13'd0;
                if (sel_none)                state_d = S_BANK;
                else if (bank_q == BANK_ID)  state_d = S_DATA;
                else                         state_d = S_SKIP;
              end
            end
          end
          S_DATA, S_SKIP: begin
            if (state_q == S_DATA) begin
              wr_req_d  = 1'b1;
              wr_addr_d = {ptr_q, cnt_q};
              wr_data_d = dl_data;
            end
            cnt_d = cnt_q + 13'd1;
            if (cnt_q == 13'(CHUNK_BYTES - 1)) begin
              if (last_chunk) state_d = S_BANK;
              else            ptr_d   = sel_idx;
            end
          end
          default: ;
        endcase
      end

      // End of file is judged on the state reached after any coincident byte.
      if (fall) begin
        case (state_d)
          S_BANK: begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
          S_TYPE, S_DATA, S_SKIP: begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= S_IDLE;
      active_q  <= 1'b0;
      bank_q    <= 8'h00;
      tidx_q    <= 3'd0;
      dmask_q   <= 8'h00;
      pmap_q    <= 8'h00;
      prom_q    <= 8'h00;
      ptr_q     <= 3'd0;
      cnt_q     <= 13'd0;
      wr_req_q  <= 1'b0;
      wr_addr_q <= 16'h0000;
      wr_data_q <= 8'h00;
      map_q     <= 8'h00;
      rom_q     <= 8'h00;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      active_q  <= dl_active;
      bank_q    <= bank_d;
      tidx_q    <= tidx_d;
      dmask_q   <= dmask_d;
      pmap_q    <= pmap_d;
      prom_q    <= prom_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      wr_req_q  <= wr_req_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      map_q     <= map_d;
      rom_q     <= rom_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign wr_req   = wr_req_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign dock_map = map_q;
  assign dock_rom = rom_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_dck_loader.sv
// Self-checking bench for dck_loader: random data bytes, file-level parse model.
module tb_dck_loader;

  localparam logic [7:0] BANK_ID = 8'd0;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        dl_active;
  logic        dl_wr;
  logic [7:0]  dl_data;
  logic        wr_req;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic [7:0]  dock_map;
  logic [7:0]  dock_rom;
  logic        done;
  logic        error;

  dck_loader #(.BANK_ID(BANK_ID)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .dl_active (dl_active),
    .dl_wr     (dl_wr),
    .dl_data   (dl_data),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .dock_map  (dock_map),
    .dock_rom  (dock_rom),
    .done      (done),
    .error     (error)
  );

  always #5 clk_sys = ~clk_sys;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          wr_count = 0;
  int          exp_writes;
  logic [7:0]  file_q[$];
  logic [23:0] exp_q[$];
  logic [7:0]  exp_map, exp_rom;
  logic        exp_done, exp_err;

  // Append one block: bank byte, types t0..t7 (t0 in bits 7:0), random data.
  task automatic push_block(input logic [7:0] bank, input logic [63:0] types);
    logic [7:0] t;
    file_q.push_back(bank);
    for (int i = 0; i < 8; i++) file_q.push_back(types[8*i +: 8]);
    for (int i = 0; i < 8; i++) begin
      t = types[8*i +: 8];
      if (t == 8'd2 || t == 8'd3)
        for (int j = 0; j < 8192; j++) file_q.push_back(8'($urandom_range(0, 255)));
    end
  endtask

  task automatic truncate_file(input int n);
    while (file_q.size() > n) void'(file_q.pop_back());
  endtask

  // Walk the file block by block and predict writes and final flags.
  task automatic model_run();
    int         p;
    logic [7:0] bank;
    logic [7:0] tv[8];
    exp_map = 8'h00; exp_rom = 8'h00; exp_done = 1'b0; exp_err = 1'b0;
    exp_writes = 0;
    p = 0;
    forever begin
      if (p >= file_q.size()) begin exp_done = 1'b1; return; end
      bank = file_q[p]; p++;
      for (int i = 0; i < 8; i++) begin
        if (p >= file_q.size()) begin exp_err = 1'b1; return; end
        tv[i] = file_q[p]; p++;
        if (tv[i] > 8'd3) begin exp_err = 1'b1; return; end
      end
      if (bank == BANK_ID)
        for (int i = 0; i < 8; i++) begin
          if (tv[i] != 8'd0) exp_map[i] = 1'b1;
          if (tv[i] == 8'd2) exp_rom[i] = 1'b1;
        end
      for (int i = 0; i < 8; i++) begin
        if (tv[i] >= 8'd2)
          for (int j = 0; j < 8192; j++) begin
            if (p >= file_q.size()) begin exp_err = 1'b1; return; end
            if (bank == BANK_ID) begin
              exp_q.push_back({16'(i * 8192 + j), file_q[p]});
              exp_writes++;
            end
            p++;
          end
      end
    end
  endtask

  // mode 0: drop after last byte; 1: drop with last byte; 2: reset instead of drop.
  task automatic send_file(input int mode);
    @(negedge clk_sys);
    dl_active = 1'b1;
    @(negedge clk_sys);
    for (int i = 0; i < file_q.size(); i++) begin
      if ($urandom_range(0, 15) == 0) begin
        dl_wr = 1'b0;
        @(negedge clk_sys);
      end
      dl_wr   = 1'b1;
      dl_data = file_q[i];
      if (mode == 1 && i == file_q.size() - 1) dl_active = 1'b0;
      @(negedge clk_sys);
    end
    dl_wr = 1'b0;
    if (mode == 2) begin
      @(negedge clk_sys);
      reset = 1'b1; dl_wr = 1'b1; dl_data = 8'hA5;
      @(negedge clk_sys);
      dl_active = 1'b0; dl_wr = 1'b0;
      @(negedge clk_sys);
      reset = 1'b0;
    end else begin
      dl_active = 1'b0;
    end
    repeat (4) @(negedge clk_sys);
  endtask

  task automatic test_reset();
    reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_data = 8'h00;
    repeat (3) @(negedge clk_sys);
    n_checks++;
    if ({wr_req, wr_addr, wr_data} !== 25'd0) begin
      n_fail++; $display("FAIL reset_wr got %h want 0", {wr_req, wr_addr, wr_data});
    end
    n_checks++;
    if ({dock_map, dock_rom, done, error} !== 18'd0) begin
      n_fail++; $display("FAIL reset_flags got %h want 0", {dock_map, dock_rom, done, error});
    end
    reset = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic test_single_rom();
    file_q.delete(); push_block(8'h00, 64'h0000_0000_0000_0002);
    model_run(); wr_count = 0;
    send_file(1);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_pending got %0d want 0", exp_q.size()); end
    n_checks++;
    if (wr_count != exp_writes) begin n_fail++; $display("FAIL single_count got %0d want %0d", wr_count, exp_writes); end
    n_checks++;
    if ({dock_map, dock_rom, done, error} !== {exp_map, exp_rom, exp_done, exp_err}) begin
      n_fail++; $display("FAIL single_flags got %h want %h", {dock_map, dock_rom, done, error}, {exp_map, exp_rom, exp_done, exp_err});
    end
  endtask

  task automatic test_idle_writes();
    for (int i = 0; i < 6; i++) begin
      dl_wr = 1'b1; dl_data = 8'(i + 1);
      @(negedge clk_sys);
    end
    dl_wr = 1'b0;
    repeat (3) @(negedge clk_sys);
    n_checks++;
    if ({dock_map, dock_rom, done, error} !== {exp_map, exp_rom, exp_done, exp_err}) begin
      n_fail++; $display("FAIL idle_flags got %h want %h", {dock_map, dock_rom, done, error}, {exp_map, exp_rom, exp_done, exp_err});
    end
  endtask

  task automatic test_two_chunks();
    file_q.delete(); push_block(8'h00, 64'h0200_0103_0000_0000);
    model_run(); wr_count = 0;
    send_file(0);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL two_pending got %0d want 0", exp_q.size()); end
    n_checks++;
    if (wr_count != exp_writes) begin n_fail++; $display("FAIL two_count got %0d want %0d", wr_count, exp_writes); end
    n_checks++;
    if ({dock_map, dock_rom, done, error} !== {exp_map, exp_rom, exp_done, exp_err}) begin
      n_fail++; $display("FAIL two_flags got %h want %h", {dock_map, dock_rom, done, error}, {exp_map, exp_rom, exp_done, exp_err});
    end
  endtask

  task automatic test_skip_bank();
    file_q.delete();
    push_block(8'hFF, 64'h0000_0000_0003_0000);
    push_block(8'h00, 64'h0000_0000_0000_0300);
    model_run(); wr_count = 0;
    send_file(0);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL skip_pending got %0d want 0", exp_q.size()); end
    n_checks++;
    if (wr_count != exp_writes) begin n_fail++; $display("FAIL skip_count got %0d want %0d", wr_count, exp_writes); end
    n_checks++;
    if ({dock_map, dock_rom, done, error} !== {exp_map, exp_rom, exp_done, exp_err}) begin
      n_fail++; $display("FAIL skip_flags got %h want %h", {dock_map, dock_rom, done, error}, {exp_map, exp_rom, exp_done, exp_err});
    end
  endtask

  task automatic test_no_data_blocks();
    file_q.delete();
    push_block(8'h00, 64'h0000_0000_0000_0001);
    push_block(8'h00, 64'h0000_0000_0000_0100);
    push_block(8'h07, 64'h0000_0000_0100_0000);
    model_run(); wr_count = 0;
    send_file(0);
    n_checks++;
    if (wr_count != 0) begin n_fail++; $display("FAIL nodata_count got %0d want 0", wr_count); end
    n_checks++;
    if ({dock_map, dock_rom, done, error} !== {exp_map, exp_rom, exp_done, exp_err}) begin
      n_fail++; $display("FAIL nodata_flags got %h want %h", {dock_map, dock_rom, done, error}, {exp_map, exp_rom, exp_done, exp_err});
    end
  endtask

  task automatic test_truncated();
    file_q.delete(); push_block(8'h00, 64'h0000_0300_0000_0000);
    truncate_file(9 + 100);
    model_run(); wr_count = 0;
    send_file(0);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL trunc_pending got %0d want 0", exp_q.size()); end
    n_checks++;
    if (wr_count != 100) begin n_fail++; $display("FAIL trunc_count got %0d want 100", wr_count); end
    n_checks++;
    if ({dock_map, dock_rom, done, error} !== {exp_map, exp_rom, exp_done, exp_err}) begin
      n_fail++; $display("FAIL trunc_flags got %h want %h", {dock_map, dock_rom, done, error}, {exp_map, exp_rom, exp_done, exp_err});
    end
  endtask

  task automatic test_bad_type();
    file_q.delete(); push_block(8'h00, 64'h0000_0000_0000_0501);
    for (int i = 0; i < 3; i++) file_q.push_back(8'($urandom_range(0, 255)));
    model_run(); wr_count = 0;
    send_file(0);
    n_checks++;
    if (wr_count != 0) begin n_fail++; $display("FAIL badtype_count got %0d want 0", wr_count); end
    n_checks++;
    if ({dock_map, dock_rom, done, error} !== {exp_map, exp_rom, exp_done, exp_err}) begin
      n_fail++; $display("FAIL badtype_flags got %h want %h", {dock_map, dock_rom, done, error}, {exp_map, exp_rom, exp_done, exp_err});
    end
  endtask

  task automatic test_reset_mid();
    file_q.delete(); push_block(8'h00, 64'h0000_0000_0000_0002);
    truncate_file(9 + 200);
    model_run(); wr_count = 0;
    send_file(2);
    n_checks++;
    if (exp_q.size() != 0 || wr_count != 200) begin
      n_fail++; $display("FAIL rstmid_writes got %0d pending %0d want 200 pending 0", wr_count, exp_q.size());
    end
    n_checks++;
    if ({dock_map, dock_rom, done, error, wr_addr} !== 34'd0) begin
      n_fail++; $display("FAIL rstmid_cleared got %h want 0", {dock_map, dock_rom, done, error, wr_addr});
    end
    file_q.delete(); push_block(8'h00, 64'h0000_0000_0300_0000);
    truncate_file(9 + 50);
    model_run(); wr_count = 0;
    send_file(0);
    n_checks++;
    if (exp_q.size() != 0 || wr_count != exp_writes) begin
      n_fail++; $display("FAIL restart_writes got %0d pending %0d want %0d", wr_count, exp_q.size(), exp_writes);
    end
    n_checks++;
    if ({dock_map, dock_rom, done, error} !== {exp_map, exp_rom, exp_done, exp_err}) begin
      n_fail++; $display("FAIL restart_flags got %h want %h", {dock_map, dock_rom, done, error}, {exp_map, exp_rom, exp_done, exp_err});
    end
  endtask

  initial begin
    logic [23:0] e;
    reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_data = 8'h00;
    // Write monitor: every wr_req must match the head of the expected queue.
    fork
      forever begin
        @(negedge clk_sys);
        if (wr_req === 1'b1) begin
          wr_count++;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write got addr %h data %h want none", wr_addr, wr_data);
          end else begin
            e = exp_q.pop_front();
            if ({wr_addr, wr_data} !== e) begin
              n_fail++;
              $display("FAIL write got addr %h data %h want addr %h data %h", wr_addr, wr_data, e[23:8], e[7:0]);
            end
          end
        end
      end
    join_none

    test_reset();
    test_single_rom();
    test_idle_writes();
    test_two_chunks();
    test_skip_bank();
    test_no_data_blocks();
    test_truncated();
    test_bad_type();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
